// File: rtl/epl_firddist_ctrl_pkg.sv
// Shared widths and FSM encodings for the read-disturb campaign sequencer.
package epl_firddist_ctrl_pkg;

    localparam int ADDR_WIDTH  = 4;
    localparam int WORD        = 1 << ADDR_WIDTH;  // one mask bit per addressable word
    localparam int TWORD_WIDTH = 8;                // parity word width
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        FICTL_IDLE  = 2'b00,
        FICTL_ARMED = 2'b01,
        FICTL_DONE  = 2'b10
    } ficState_t;

endpackage

// File: rtl/epl_firddist_ctrl_if.sv
// Campaign configuration handshake between a requester and the sequencer.
interface epl_firddist_ctrl_if
    import epl_firddist_ctrl_pkg::*;
    #(parameter int CNT_W = CNT_W_DEF);

    logic                   pCfgValid_i;
    logic                   pCfgReady_o;
    logic [WORD-1:0]        pCfgWordMask_i;
    logic [TWORD_WIDTH-1:0] pCfgBitMask_i;
    logic [CNT_W-1:0]       pCfgCount_i;
    logic                   pCfgWalk_i;

    modport master (
        output pCfgValid_i, pCfgWordMask_i, pCfgBitMask_i, pCfgCount_i, pCfgWalk_i,
        input  pCfgReady_o
    );

    modport slave (
        input  pCfgValid_i, pCfgWordMask_i, pCfgBitMask_i, pCfgCount_i, pCfgWalk_i,
        output pCfgReady_o
    );

endinterface

// File: rtl/epl_firddist_ctrl.sv
// Read-disturb fault-injection campaign sequencer. Drives the injector enable
// and masks, snoops the injector's address/strobe to count real injections,
// optionally walks the bit mask, and closes after a programmed count or abort.
module epl_firddist_ctrl
    import epl_firddist_ctrl_pkg::*;
    #(parameter int CNT_W = CNT_W_DEF)
(
    input  logic                   pCLK_i,
    input  logic                   pRST_i,
    epl_firddist_ctrl_if.slave     cfg,
    input  logic                   pAbort_i,
    input  logic [ADDR_WIDTH-1:0]  pA_i,
    input  logic                   pREAD_i,
    output logic                   pFIEN_o,
    output logic [WORD-1:0]        pFiWordMask_o,
    output logic [TWORD_WIDTH-1:0] pFiBitMask_o,
    output logic                   pBusy_o,
    output logic                   pDone_o,
    output logic [CNT_W-1:0]       pInjCnt_o
);

    ficState_t        state;
    logic [CNT_W-1:0] countQ;
    logic             walkQ;
    logic             hit;
    logic             lastHit;

    // Same condition the injector uses, so every counted hit really flipped bits.
    assign hit     = (state == FICTL_ARMED) & pREAD_i & pFiWordMask_o[pA_i];
    // Final injection of a bounded campaign; count 0 never completes.
    assign lastHit = hit & (countQ != '0)
                   & (({1'b0, pInjCnt_o} + 1'b1) == {1'b0, countQ});

    assign cfg.pCfgReady_o = (state == FICTL_IDLE) & ~pRST_i;

    // Campaign FSM with registered injector controls, counter and mask walk.
    always_ff @(posedge pCLK_i) begin
        if (pRST_i) begin
            state         <= FICTL_IDLE;
            countQ        <= '0;
            walkQ         <= 1'b0;
            pFIEN_o       <= 1'b0;
            pFiWordMask_o <= '0;
            pFiBitMask_o  <= '0;
            pBusy_o       <= 1'b0;
            pDone_o       <= 1'b0;
            pInjCnt_o     <= '0;
        end else begin
            case (state)
                FICTL_IDLE: begin
                    pDone_o <= 1'b0;
                    if (cfg.pCfgValid_i) begin
                        pFiWordMask_o <= cfg.pCfgWordMask_i;
                        pFiBitMask_o  <= cfg.pCfgBitMask_i;
                        countQ        <= cfg.pCfgCount_i;
                        walkQ         <= cfg.pCfgWalk_i;
                        pInjCnt_o     <= '0;
                        pFIEN_o       <= 1'b1;
                        pBusy_o       <= 1'b1;
                        state         <= FICTL_ARMED;
                    end
                end
                FICTL_ARMED: begin
                    // A hit coinciding with abort already happened on the read
                    // path, so it is accounted for regardless of the exit taken.
                    if (hit) begin
                        if (pInjCnt_o != '1)
                            pInjCnt_o <= pInjCnt_o + 1'b1;
                        if (walkQ)
                            pFiBitMask_o <= {pFiBitMask_o[TWORD_WIDTH-2:0],
                                             pFiBitMask_o[TWORD_WIDTH-1]};
                    end
                    if (pAbort_i) begin
                        pFIEN_o <= 1'b0;
                        pBusy_o <= 1'b0;
                        state   <= FICTL_IDLE;
                    end else if (lastHit) begin
                        pFIEN_o <= 1'b0;
                        pBusy_o <= 1'b0;
                        pDone_o <= 1'b1;
                        state   <= FICTL_DONE;
                    end
                end
                FICTL_DONE: begin
                    pDone_o <= 1'b0;
                    state   <= FICTL_IDLE;
                end
                default: begin
                    pFIEN_o <= 1'b0;
                    pBusy_o <= 1'b0;
                    pDone_o <= 1'b0;
                    state   <= FICTL_IDLE;
                end
            endcase
        end
    end

endmodule
